// File: rtl/inst_mem_loadable.sv
// -----------------------------------------------------------------------------
// inst_mem_loadable
//   Loadable instruction memory for the pipelined MIPS core. Word-addressed by
//   the fetch-stage PC, with a one-cycle registered read that holds its value
//   while the core stalls. A byte-serial load port fills the array at run time.
//   Fetches from words not covered by the most recent load, and fetches outside
//   the array, return DEFAULT_WORD.
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   reset_ni         asynchronous active-low reset
//   fetch_en_i       1 = sample addr_i this cycle, 0 = stall (hold data)
//   addr_i[31:0]     byte address from PC, word index = addr_i[AW+1:2]
//   data_o[31:0]     registered instruction word
//   data_valid_o     data_o holds a fetched word
//   misaligned_o     addr_i[1:0] != 0 when data_o was sampled
//   ld_start_i       pulse: begin / restart an image load
//   ld_byte_i[7:0]   load data byte
//   ld_byte_valid_i  ld_byte_i is presented
//   ld_last_i        marks the final byte of the image
//   ld_ready_o       load bytes are accepted this cycle
//   ld_done_o        one-cycle pulse when the load completes
//   ld_overflow_o    sticky: image was longer than DEPTH words
//   cpu_hold_o       core must stall while loading
// -----------------------------------------------------------------------------
module inst_mem_loadable #(
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned AW           = $clog2(DEPTH),
    parameter logic [31:0] DEFAULT_WORD = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        fetch_en_i,
    input  logic [31:0] addr_i,
    output logic [31:0] data_o,
    output logic        data_valid_o,
    output logic        misaligned_o,
    input  logic        ld_start_i,
    input  logic [7:0]  ld_byte_i,
    input  logic        ld_byte_valid_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    output logic        ld_done_o,
    output logic        ld_overflow_o,
    output logic        cpu_hold_o
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [AW:0] FULL_PTR = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    // Place byte b into lane cnt on top of the already collected lower lanes;
    // lanes above cnt stay zero so a short final word is zero-padded.
    function automatic logic [31:0] lane_merge(input logic [23:0] partial,
                                               input logic [1:0]  cnt,
                                               input logic [7:0]  b);
        logic [31:0] w;
        case (cnt)
            2'd0:    w = {24'h00_0000, b};
            2'd1:    w = {16'h0000, b, partial[7:0]};
            2'd2:    w = {8'h00, b, partial[15:0]};
            2'd3:    w = {b, partial[23:0]};
            default: w = {24'h00_0000, b};
        endcase
        return w;
    endfunction

    logic [31:0] mem_q [DEPTH];

    state_e      state_q, state_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] ld_words_q, ld_words_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] asm_q, asm_d;
    logic        ld_overflow_q, ld_overflow_d;
    logic [31:0] data_q, data_d;
    logic        data_valid_q, data_valid_d;
    logic        misaligned_q, misaligned_d;
    logic        ld_ready_q, ld_ready_d;
    logic        ld_done_q, ld_done_d;
    logic        cpu_hold_q, cpu_hold_d;

    logic          start_s;
    logic          byte_accept_s;
    logic          word_done_s;
    logic          mem_we_s;
    logic [31:0]   merged_s;
    logic [AW-1:0] fetch_idx_s;
    logic          fetch_hit_s;
    logic [31:0]   fetch_word_s;

    // A start pulse only restarts from RUN or LOAD; DONE always falls back to RUN.
    assign start_s       = ld_start_i & (state_q != ST_DONE);
    // The start cycle swallows any byte presented alongside it.
    assign byte_accept_s = (state_q == ST_LOAD) & ld_byte_valid_i & ~ld_start_i;
    assign word_done_s   = byte_accept_s & ((byte_cnt_q == 2'd3) | ld_last_i);
    assign merged_s      = lane_merge(asm_q, byte_cnt_q, ld_byte_i);

    assign fetch_idx_s  = addr_i[AW+1:2];
    // Only words written by the current load are visible; everything else,
    // including addresses past the array, reads as the default word.
    assign fetch_hit_s  = ~(|addr_i[31:AW+2]) & ({1'b0, fetch_idx_s} < ld_words_q);
    assign fetch_word_s = fetch_hit_s ? mem_q[fetch_idx_s] : DEFAULT_WORD;

    // State register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ld_start_i) state_d = ST_LOAD;
                else            state_d = ST_RUN;
            end
            ST_LOAD: begin
                if (ld_start_i)                      state_d = ST_LOAD;
                else if (byte_accept_s && ld_last_i) state_d = ST_DONE;
                else                                 state_d = ST_LOAD;
            end
            ST_DONE: state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // Status outputs decoded from the upcoming state so they leave flops.
    always_comb begin
        ld_ready_d = (state_d == ST_LOAD);
        ld_done_d  = (state_d == ST_DONE);
        cpu_hold_d = (state_d != ST_RUN);
    end

    // Load datapath: byte assembly, write pointer, loaded-word count, overflow.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        ld_words_d    = ld_words_q;
        byte_cnt_d    = byte_cnt_q;
        asm_d         = asm_q;
        ld_overflow_d = ld_overflow_q;
        mem_we_s      = 1'b0;
        if (start_s) begin
            wr_ptr_d      = '0;
            ld_words_d    = '0;
            byte_cnt_d    = 2'd0;
            asm_d         = 24'h00_0000;
            ld_overflow_d = 1'b0;
        end else if (word_done_s) begin
            byte_cnt_d = 2'd0;
            asm_d      = 24'h00_0000;
            if (wr_ptr_q == FULL_PTR) begin
                // Array full: drop the word, ld_words already equals DEPTH.
                ld_overflow_d = 1'b1;
            end else begin
                mem_we_s   = 1'b1;
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                ld_words_d = wr_ptr_q + PTR_ONE;
            end
        end else if (byte_accept_s) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            asm_d      = merged_s[23:0];
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Fetch port: sample in RUN when enabled, hold on stall, invalidate while loading.
    always_comb begin
        data_d       = data_q;
        data_valid_d = data_valid_q;
        misaligned_d = misaligned_q;
        if (state_q == ST_RUN) begin
            if (fetch_en_i) begin
                data_d       = fetch_word_s;
                data_valid_d = 1'b1;
                misaligned_d = |addr_i[1:0];
            end else begin
                data_valid_d = data_valid_q;
            end
        end else begin
            data_valid_d = 1'b0;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q      <= '0;
            ld_words_q    <= '0;
            byte_cnt_q    <= 2'd0;
            asm_q         <= 24'h00_0000;
            ld_overflow_q <= 1'b0;
            data_q        <= 32'h0000_0000;
            data_valid_q  <= 1'b0;
            misaligned_q  <= 1'b0;
            ld_ready_q    <= 1'b0;
            ld_done_q     <= 1'b0;
            cpu_hold_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            ld_words_q    <= ld_words_d;
            byte_cnt_q    <= byte_cnt_d;
            asm_q         <= asm_d;
            ld_overflow_q <= ld_overflow_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            misaligned_q  <= misaligned_d;
            ld_ready_q    <= ld_ready_d;
            ld_done_q     <= ld_done_d;
            cpu_hold_q    <= cpu_hold_d;
        end
    end

    // Instruction storage; contents are undefined until loaded.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= merged_s;
        end
    end

    assign data_o        = data_q;
    assign data_valid_o  = data_valid_q;
    assign misaligned_o  = misaligned_q;
    assign ld_ready_o    = ld_ready_q;
    assign ld_done_o     = ld_done_q;
    assign ld_overflow_o = ld_overflow_q;
    assign cpu_hold_o    = cpu_hold_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
// -----------------------------------------------------------------------------
// Testbench for inst_mem_loadable. Two instances share all inputs: a 256-word
// memory and a 4-word memory for overflow behaviour. Expected fetch results
// come from the byte image last loaded, packed little-endian with arithmetic.
// -----------------------------------------------------------------------------
module tb_inst_mem_loadable;

    localparam logic [31:0] DEF = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_en;
    logic [31:0] addr;
    logic        ld_start;
    logic [7:0]  ld_byte;
    logic        ld_byte_valid;
    logic        ld_last;

    logic [31:0] data, data4;
    logic        data_valid, valid4, misaligned, mis4;
    logic        ld_ready, ready4, ld_done, done4, ld_overflow, ovf4, cpu_hold, hold4;

    int checks = 0;
    int errors = 0;

    logic [7:0] img[$];

    // observations recorded by load_img
    logic rdy_seen, hold_seen, ovf4_seen, early_done, done_seen, done4_seen;
    logic done_next, hold_next, valid_next;

    inst_mem_loadable #(.DEPTH(256)) dut (
        .clk_i(clk), .reset_ni(rst_n), .fetch_en_i(fetch_en), .addr_i(addr),
        .data_o(data), .data_valid_o(data_valid), .misaligned_o(misaligned),
        .ld_start_i(ld_start), .ld_byte_i(ld_byte), .ld_byte_valid_i(ld_byte_valid),
        .ld_last_i(ld_last), .ld_ready_o(ld_ready), .ld_done_o(ld_done),
        .ld_overflow_o(ld_overflow), .cpu_hold_o(cpu_hold)
    );

    inst_mem_loadable #(.DEPTH(4)) dut4 (
        .clk_i(clk), .reset_ni(rst_n), .fetch_en_i(fetch_en), .addr_i(addr),
        .data_o(data4), .data_valid_o(valid4), .misaligned_o(mis4),
        .ld_start_i(ld_start), .ld_byte_i(ld_byte), .ld_byte_valid_i(ld_byte_valid),
        .ld_last_i(ld_last), .ld_ready_o(ready4), .ld_done_o(done4),
        .ld_overflow_o(ovf4), .cpu_hold_o(hold4)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: word visible at byte address a for a memory of 'depth' words.
    function automatic logic [31:0] exp_word(input logic [31:0] a, input int depth);
        longint idx = longint'(a) >> 2;
        longint nw  = (img.size() + 3) / 4;
        logic [31:0] w = 32'h0;
        if (nw > depth) nw = depth;
        if (idx >= nw) return DEF;
        for (int j = 0; j < 4; j++)
            if (idx * 4 + j < img.size()) w = w | (32'(img[idx * 4 + j]) << (8 * j));
        return w;
    endfunction

    function automatic logic exp_ovf(input int depth);
        return ((img.size() + 3) / 4) > depth;
    endfunction

    task automatic do_fetch(input logic [31:0] a, input logic en);
        fetch_en = en;
        addr     = a;
        step();
    endtask

    // Streams img (with optional random idle gaps) after a start pulse.
    task automatic load_img(input int gap_max);
        fetch_en = 1'b0; ld_start = 1'b1; ld_byte_valid = 1'b0; ld_last = 1'b0;
        step();
        ld_start   = 1'b0;
        rdy_seen   = ld_ready;
        hold_seen  = cpu_hold;
        ovf4_seen  = ovf4;
        early_done = 1'b0;
        for (int i = 0; i < img.size(); i++) begin
            int g = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            repeat (g) begin ld_byte_valid = 1'b0; ld_last = 1'b0; step(); end
            ld_byte = img[i]; ld_byte_valid = 1'b1; ld_last = (i == img.size() - 1);
            step();
            if (i != img.size() - 1 && ld_done) early_done = 1'b1;
        end
        done_seen  = ld_done;
        done4_seen = done4;
        ld_byte_valid = 1'b0; ld_last = 1'b0;
        step();
        done_next  = ld_done;
        hold_next  = cpu_hold;
        valid_next = data_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_en = 1'b0; addr = 32'h0; ld_start = 1'b0;
        ld_byte = 8'h00; ld_byte_valid = 1'b0; ld_last = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", data, 32'h0); end
        checks++; if ({data_valid, misaligned, ld_ready, ld_done, ld_overflow, cpu_hold} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {data_valid, misaligned, ld_ready, ld_done, ld_overflow, cpu_hold}); end
        do_fetch(32'h0, 1'b1);
        checks++; if (data !== DEF) begin errors++; $display("FAIL reset_fetch_data: got %h expected %h", data, DEF); end
        checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL reset_fetch_valid: got %b expected 1", data_valid); end
    endtask

    task automatic test_basic_load();
        img = {8'h00, 8'h00, 8'h08, 8'h3C, 8'h01, 8'h01, 8'h09, 8'h21};
        load_img(0);
        checks++; if ({rdy_seen, hold_seen} !== 2'b11) begin errors++; $display("FAIL load_ready_hold: got %b expected 11", {rdy_seen, hold_seen}); end
        checks++; if ({early_done, done_seen, done_next} !== 3'b010) begin errors++; $display("FAIL load_done_pulse: got %b expected 010", {early_done, done_seen, done_next}); end
        checks++; if ({hold_next, valid_next} !== 2'b00) begin errors++; $display("FAIL load_release: got %b expected 00", {hold_next, valid_next}); end
        do_fetch(32'h0, 1'b1);
        checks++; if (data !== 32'h3C080000) begin errors++; $display("FAIL basic_w0: got %h expected %h", data, 32'h3C080000); end
        do_fetch(32'h4, 1'b1);
        checks++; if (data !== 32'h21090101) begin errors++; $display("FAIL basic_w1: got %h expected %h", data, 32'h21090101); end
        do_fetch(32'h8, 1'b1);
        checks++; if (data !== DEF) begin errors++; $display("FAIL basic_w2_default: got %h expected %h", data, DEF); end
    endtask

    task automatic test_short_load();
        img = {8'hAA, 8'hBB};
        load_img(0);
        checks++; if (done_seen !== 1'b1) begin errors++; $display("FAIL short_done: got %b expected 1", done_seen); end
        do_fetch(32'h0, 1'b1);
        checks++; if (data !== 32'h0000BBAA) begin errors++; $display("FAIL short_w0: got %h expected %h", data, 32'h0000BBAA); end
        do_fetch(32'h4, 1'b1);
        checks++; if (data !== DEF) begin errors++; $display("FAIL short_w1_default: got %h expected %h", data, DEF); end
    endtask

    task automatic test_stall_misaligned();
        img = {8'h00, 8'h00, 8'h08, 8'h3C, 8'h01, 8'h01, 8'h09, 8'h21};
        load_img(0);
        do_fetch(32'h4, 1'b1);
        do_fetch(32'h0, 1'b0);
        do_fetch(32'h8, 1'b0);
        do_fetch(32'h400, 1'b0);
        checks++; if (data !== 32'h21090101 || data_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold: got %h/%b expected %h/1", data, data_valid, 32'h21090101); end
        do_fetch(32'h6, 1'b1);
        checks++; if (data !== 32'h21090101 || misaligned !== 1'b1) begin
            errors++; $display("FAIL misaligned: got %h/%b expected %h/1", data, misaligned, 32'h21090101); end
        do_fetch(32'h400, 1'b1);
        checks++; if (data !== DEF || misaligned !== 1'b0 || data4 !== DEF) begin
            errors++; $display("FAIL out_of_range: got %h/%b/%h expected %h/0/%h", data, misaligned, data4, DEF, DEF); end
    endtask

    task automatic test_overflow();
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(8'h10 + i));
        load_img(1);
        checks++; if (done4_seen !== 1'b1) begin errors++; $display("FAIL ovf_done4: got %b expected 1", done4_seen); end
        checks++; if (ovf4 !== 1'b1 || ld_overflow !== 1'b0) begin
            errors++; $display("FAIL ovf_flag: got %b/%b expected 1/0", ovf4, ld_overflow); end
        for (int w = 0; w < 5; w++) begin
            logic [31:0] a = 32'(w * 4);
            do_fetch(a, 1'b1);
            checks++; if (data4 !== exp_word(a, 4) || data !== exp_word(a, 256)) begin
                errors++; $display("FAIL ovf_word%0d: got %h/%h expected %h/%h", w, data4, data, exp_word(a, 4), exp_word(a, 256)); end
        end
        img = {8'h01, 8'h02, 8'h03, 8'h04};
        load_img(0);
        checks++; if (ovf4_seen !== 1'b0) begin errors++; $display("FAIL ovf_clear_on_start: got %b expected 0", ovf4_seen); end
    endtask

    task automatic test_restart();
        fetch_en = 1'b0; ld_start = 1'b1; step();
        ld_start = 1'b0;
        ld_byte_valid = 1'b1; ld_byte = 8'h11; step();
        ld_byte = 8'h22; step();
        // start together with a "last" byte: the byte must be dropped
        ld_start = 1'b1; ld_byte = 8'hEE; ld_last = 1'b1; step();
        ld_start = 1'b0; ld_byte_valid = 1'b0; ld_last = 1'b0;
        checks++; if ({ld_ready, ld_done, cpu_hold} !== 3'b101) begin
            errors++; $display("FAIL start_wins: got %b expected 101", {ld_ready, ld_done, cpu_hold}); end
        img = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        load_img(0);
        do_fetch(32'h0, 1'b1);
        checks++; if (data !== 32'hEFBEADDE) begin errors++; $display("FAIL restart_w0: got %h expected %h", data, 32'hEFBEADDE); end
        do_fetch(32'h4, 1'b1);
        checks++; if (data !== DEF) begin errors++; $display("FAIL restart_w1_default: got %h expected %h", data, DEF); end
    endtask

    task automatic test_random();
        logic [31:0] e_data, e_data4, a;
        logic        e_valid, e_mis, en;
        for (int r = 0; r < 12; r++) begin
            int n = $urandom_range(40, 1);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(8'($urandom));
            load_img(2);
            checks++; if (done_seen !== 1'b1 || ovf4 !== exp_ovf(4) || ld_overflow !== exp_ovf(256)) begin
                errors++; $display("FAIL rand_load%0d: got done=%b ovf4=%b ovf=%b expected 1/%b/%b",
                                   r, done_seen, ovf4, ld_overflow, exp_ovf(4), exp_ovf(256)); end
            e_valid = 1'b0; e_data = 32'h0; e_data4 = 32'h0; e_mis = 1'b0;
            for (int f = 0; f < 25; f++) begin
                case ($urandom_range(3, 0))
                    0, 1:    a = 32'($urandom_range(n + 12, 0));
                    2:       a = 32'($urandom_range(63, 0)) << 2;
                    default: a = $urandom;
                endcase
                en = (f == 0) ? 1'b1 : ($urandom_range(3, 0) != 0);
                do_fetch(a, en);
                if (en) begin
                    e_data = exp_word(a, 256); e_data4 = exp_word(a, 4);
                    e_valid = 1'b1; e_mis = (a[1:0] != 2'b00);
                end
                checks++; if (data !== e_data || data4 !== e_data4 || data_valid !== e_valid || misaligned !== e_mis) begin
                    errors++; $display("FAIL rand_fetch r%0d f%0d addr %h: got %h/%h/%b/%b expected %h/%h/%b/%b",
                                       r, f, a, data, data4, data_valid, misaligned, e_data, e_data4, e_valid, e_mis); end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        load_img(0);
        fetch_en = 1'b0; ld_start = 1'b1; step();
        ld_start = 1'b0; ld_byte_valid = 1'b1; ld_byte = 8'h55;
        repeat (3) step();
        ld_byte_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++; if ({cpu_hold, ld_ready, hold4} !== 3'b000) begin
            errors++; $display("FAIL mid_reset_hold: got %b expected 000", {cpu_hold, ld_ready, hold4}); end
        step();
        rst_n = 1'b1;
        img.delete();
        step();
        do_fetch(32'h0, 1'b1);
        checks++; if (data !== DEF || data4 !== DEF || data_valid !== 1'b1) begin
            errors++; $display("FAIL mid_reset_fetch: got %h/%h/%b expected %h/%h/1", data, data4, data_valid, DEF, DEF); end
        do_fetch(32'h4, 1'b1);
        checks++; if (data !== DEF) begin errors++; $display("FAIL mid_reset_fetch4: got %h expected %h", data, DEF); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_short_load();
        test_stall_misaligned();
        test_overflow();
        test_restart();
        test_random();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, loadable instruction memory for the pipelined MIPS core, replacing the fixed combinational test ROMs. Word-addressed by the fetch-stage PC with one-cycle registered read and stall hold. A byte-serial load port fills it from a boot/UART loader at run time. Words not yet loaded and out-of-range fetches return a fixed default instruction word.

## Interface
- DEPTH, 256: number of 32-bit words; power of two, 4..4096.
- AW, log2(DEPTH): word-index width.
- DEFAULT_WORD, 32'h80000000: word returned for unloaded or out-of-range fetches.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  1 = sample addr this cycle; 0 = stall, hold data.
- addr  in  32  byte address from PC; word index = addr[AW+1:2].
- data  out  32  instruction word, registered.
- data_valid  out  1  data holds a fetched word.
- misaligned  out  1  addr[1:0] != 0 at sample time, registered alongside data.
- ld_start  in  1  single-cycle pulse: begin/restart a load.
- ld_byte  in  8  load data byte.
- ld_byte_valid  in  1  ld_byte is presented.
- ld_last  in  1  qualifies the final byte of the image.
- ld_ready  out  1  bytes are accepted this cycle.
- ld_done  out  1  one-cycle pulse at load completion.
- ld_overflow  out  1  sticky: image exceeded DEPTH words.
- cpu_hold  out  1  core must stall; high throughout loading.

## Operation
- States: RUN, LOAD, DONE. Reset enters RUN.
- RUN -> LOAD on ld_start. LOAD -> LOAD on ld_start: restart. LOAD -> DONE on an accepted byte with ld_last. DONE -> RUN unconditionally.
- ld_start clears wr_ptr, byte_cnt, ld_words and ld_overflow.
- ld_ready = 1 only in LOAD. A byte is accepted when ld_ready & ld_byte_valid & !ld_start. In the start cycle itself, bytes are ignored.
- Byte assembly is little-endian. byte_cnt 0..3 selects lane [7:0], [15:8], [23:16], [31:24].
- On the 4th byte, or on ld_last, write the assembled word (unfilled lanes = 0) to mem[wr_ptr], increment wr_ptr, set ld_words = wr_ptr+1, clear byte_cnt.
- If wr_ptr == DEPTH when a word completes: no write; set ld_overflow; ld_words stays DEPTH.
- Memory array is not reset.
- Validity: ld_words (AW+1 bits) is reset to 0. A fetch returns DEFAULT_WORD if addr[31:AW+2] != 0 or index >= ld_words.
- RUN with fetch_en = 1: data <= selected word; data_valid <= 1; misaligned <= |addr[1:0]. Misaligned fetches still return the word at addr[AW+1:2].
- RUN with fetch_en = 0: data, data_valid and misaligned hold.
- LOAD/DONE: data_valid <= 0; data holds; fetch_en ignored.
- cpu_hold = 1 in LOAD and DONE, 0 in RUN.

## Timing
- Reset values: data = 32'h00000000 (nop), data_valid = 0, misaligned = 0, ld_ready = 0, ld_done = 0, ld_overflow = 0, cpu_hold = 0, state RUN, ld_words = 0.
- Fetch latency is 1 cycle: addr sampled at edge N appears on data after edge N.
- Load: ld_start at edge N gives ld_ready = 1 and cpu_hold = 1 from N+1.
- A word written at edge M is fetchable from the first RUN cycle.
- Accepted ld_last at edge M: DONE during M..M+1 with ld_done = 1; RUN from M+1 with cpu_hold = 0.
- Reset mid-load: immediate return to RUN with ld_words = 0. All fetches then return DEFAULT_WORD until a new load completes.
- Simultaneous ld_start and ld_byte_valid/ld_last: start wins; the byte is dropped.

## Test plan
- Reset, then fetch addr 0x0 -> data = 32'h80000000, data_valid = 1 one cycle later; before the first fetch, data = 0 and cpu_hold = 0.
- Load bytes 0x00,0x00,0x08,0x3C and 0x01,0x01,0x09,0x21 (last) -> ld_done pulse. Fetch 0x0 -> 32'h3C080000; fetch 0x4 -> 32'h21090101; fetch 0x8 -> 32'h80000000.
- Load 0xAA,0xBB with ld_last on 0xBB -> mem[0] = 32'h0000BBAA, ld_words = 1.
- Fetch 0x4, then drop fetch_en for 3 cycles while addr changes -> data held at the 0x4 word; fetch 0x6 -> misaligned = 1 with the same word. Fetch 0x400 (DEPTH = 256) -> DEFAULT_WORD.
- DEPTH = 4: load 5 words -> ld_overflow = 1, words 0-3 intact, ld_done pulses. A new ld_start clears ld_overflow.
- ld_start after 2 bytes of a load, then a 4-byte image -> earlier partial bytes discarded, ld_words = 1. Reset asserted mid-load -> cpu_hold = 0 and fetch 0x0 returns DEFAULT_WORD.
